// File: rtl/cpu_tick_gen_if.sv
// cpu_tick_gen_if: rate select, memory-ready handshake and tick outputs
// exchanged between the CPU-side top level and the tick generator.
//   speed_sel  : rate select, divisor = BASE_DIV >> speed_sel
//   mem_ready  : ROM/memory ready; ticks are withheld while low
//   tick       : one-cycle CPU clock enable
//   running    : 1 = RUN, 0 = HALT
//   tick_count : ticks issued since reset, wraps
interface cpu_tick_gen_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [1:0]           speed_sel;
    logic                 mem_ready;
    logic                 tick;
    logic                 running;
    logic [CNT_WIDTH-1:0] tick_count;

    modport master (
        output speed_sel,
        output mem_ready,
        input  tick,
        input  running,
        input  tick_count
    );

    modport slave (
        input  speed_sel,
        input  mem_ready,
        output tick,
        output running,
        output tick_count
    );
endinterface

// File: rtl/cpu_tick_gen.sv
// cpu_tick_gen: CPU clock-enable generator with selectable rate, run/halt
// toggle and single-step from debounced buttons, gated by memory ready.
// Ports:
//   clk, reset_n       : 12 MHz clock, async active-low reset
//   run_btn, step_btn  : raw asynchronous buttons, active-high
//   bus (slave)        : speed_sel, mem_ready in; tick, running, tick_count out
// Optional feature macro TICK_BREAK_EN adds a PC breakpoint:
//   pc, break_addr, break_en in; break_hit out.
module cpu_tick_gen #(
    parameter int unsigned BASE_DIV        = 187500,
    parameter int unsigned DIV_WIDTH       = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned RUN_AT_RESET    = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           run_btn,
    input  logic           step_btn,
`ifdef TICK_BREAK_EN
    input  logic [15:0]    pc,
    input  logic [15:0]    break_addr,
    input  logic           break_en,
    output logic           break_hit,
`endif
    cpu_tick_gen_if.slave  bus
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index 0 = run button, index 1 = step button
    logic [1:0]          btn_raw;
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0]          level_q;
    logic [1:0]          evt_q;
    logic [DB_W-1:0]     db_cnt_q [2];

    state_t              state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                step_pending_q;
    logic                tick_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic [DIV_WIDTH-1:0] shifted_c;
    logic [DIV_WIDTH-1:0] div_d_c;
    logic                term_c;
    logic                brk_c;
    logic                fire_c;
    logic                run_evt_c;
    logic                step_evt_c;

    assign btn_raw    = {step_btn, run_btn};
    assign run_evt_c  = evt_q[0];
    // Run wins over a simultaneous step
    assign step_evt_c = evt_q[1] & ~evt_q[0];

    // Synchronise and debounce both buttons; emit a pulse on accepted rising level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            evt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            evt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    level_q[i]  <= sync2_q[i];
                    evt_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Effective divisor, terminal detect and tick decision
    always_comb begin
        shifted_c = DIV_WIDTH'(BASE_DIV) >> bus.speed_sel;
        div_d_c   = (shifted_c == '0) ? DIV_WIDTH'(1) : shifted_c;
        // >= so that a speed change below the current count fires immediately
        term_c    = (div_q >= (div_d_c - DIV_WIDTH'(1)));
`ifdef TICK_BREAK_EN
        brk_c     = break_en && (pc == break_addr);
`else
        brk_c     = 1'b0;
`endif
        fire_c    = 1'b0;
        if (state_q == RUN) begin
            fire_c = !run_evt_c && term_c && bus.mem_ready && !brk_c;
        end else begin
            fire_c = !run_evt_c && (step_pending_q || step_evt_c) && bus.mem_ready;
        end
    end

    // Run/halt state, divider, step latch and tick outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= (RUN_AT_RESET != 0) ? RUN : HALT;
            div_q          <= '0;
            step_pending_q <= 1'b0;
            tick_q         <= 1'b0;
            count_q        <= '0;
`ifdef TICK_BREAK_EN
            break_hit      <= 1'b0;
`endif
        end else begin
            tick_q <= fire_c;
            if (fire_c) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
`ifdef TICK_BREAK_EN
            if (evt_q[0] || evt_q[1]) begin
                break_hit <= 1'b0;
            end
`endif
            case (state_q)
                RUN: begin
                    if (run_evt_c) begin
                        state_q <= HALT;
                        div_q   <= '0;
                    end else if (term_c) begin
                        // Hold at terminal until memory is ready
                        if (bus.mem_ready) begin
                            div_q <= '0;
`ifdef TICK_BREAK_EN
                            if (brk_c) begin
                                state_q   <= HALT;
                                break_hit <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        div_q <= div_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    div_q <= '0;
                    if (run_evt_c) begin
                        state_q        <= RUN;
                        step_pending_q <= 1'b0;
                    end else if (fire_c) begin
                        step_pending_q <= 1'b0;
                    end else if (step_evt_c) begin
                        step_pending_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.tick       = tick_q;
    assign bus.running    = (state_q == RUN);
    assign bus.tick_count = count_q;

endmodule

// File: tb/tb_cpu_tick_gen.sv
// tb_cpu_tick_gen: directed bench for cpu_tick_gen with BASE_DIV=8,
// DEBOUNCE_CYCLES=4 and a 4-bit tick counter.
module tb_cpu_tick_gen;

    localparam int unsigned CW = 4;

    logic clk;
    logic reset_n;
    logic run_btn;
    logic step_btn;
`ifdef TICK_BREAK_EN
    logic [15:0] pc;
    logic [15:0] break_addr;
    logic        break_en;
    logic        break_hit;
`endif

    int n_checks;
    int n_fail;

    cpu_tick_gen_if #(.CNT_WIDTH(CW)) bus ();

    cpu_tick_gen #(
        .BASE_DIV        (8),
        .DIV_WIDTH       (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (CW),
        .RUN_AT_RESET    (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
`ifdef TICK_BREAK_EN
        .pc         (pc),
        .break_addr (break_addr),
        .break_en   (break_en),
        .break_hit  (break_hit),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    speed;
        logic          mr;
        int            n;
        logic          tick;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs [22];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Press a button level; tick expected high only on edge number fire_at (0 = never)
    task automatic watch_ticks(input string name, input int n, input int fire_at);
        for (int c = 1; c <= n; c++) begin
            cyc(1);
            check(name, 32'(bus.tick), 32'(c == fire_at));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        bus.speed_sel = 2'd0;
        bus.mem_ready = 1'b1;
`ifdef TICK_BREAK_EN
        pc         = 16'h0000;
        break_addr = 16'h0010;
        break_en   = 1'b0;
`endif

        //           speed  mr    n   tick  count
        vecs[0]  = '{2'd0, 1'b1, 7,  1'b0, 4'd0};
        vecs[1]  = '{2'd0, 1'b1, 1,  1'b1, 4'd1};
        vecs[2]  = '{2'd0, 1'b1, 1,  1'b0, 4'd1};
        vecs[3]  = '{2'd0, 1'b1, 6,  1'b0, 4'd1};
        vecs[4]  = '{2'd0, 1'b1, 1,  1'b1, 4'd2};
        vecs[5]  = '{2'd0, 1'b1, 16, 1'b1, 4'd4};
        vecs[6]  = '{2'd3, 1'b1, 1,  1'b1, 4'd5};
        vecs[7]  = '{2'd3, 1'b1, 1,  1'b1, 4'd6};
        vecs[8]  = '{2'd3, 1'b1, 3,  1'b1, 4'd9};
        vecs[9]  = '{2'd3, 1'b0, 1,  1'b0, 4'd9};
        vecs[10] = '{2'd3, 1'b0, 5,  1'b0, 4'd9};
        vecs[11] = '{2'd3, 1'b1, 1,  1'b1, 4'd10};
        vecs[12] = '{2'd0, 1'b1, 5,  1'b0, 4'd10};
        vecs[13] = '{2'd1, 1'b1, 1,  1'b1, 4'd11};
        vecs[14] = '{2'd1, 1'b1, 3,  1'b0, 4'd11};
        vecs[15] = '{2'd1, 1'b1, 1,  1'b1, 4'd12};
        vecs[16] = '{2'd0, 1'b0, 10, 1'b0, 4'd12};
        vecs[17] = '{2'd0, 1'b0, 10, 1'b0, 4'd12};
        vecs[18] = '{2'd0, 1'b1, 1,  1'b1, 4'd13};
        vecs[19] = '{2'd0, 1'b1, 1,  1'b0, 4'd13};
        vecs[20] = '{2'd3, 1'b1, 3,  1'b1, 4'd0};
        vecs[21] = '{2'd3, 1'b1, 1,  1'b1, 4'd1};

        // Reset values
        cyc(2);
        check("reset_tick", 32'(bus.tick), 32'd0);
        check("reset_count", 32'(bus.tick_count), 32'd0);
        check("reset_running", 32'(bus.running), 32'd1);
        reset_n = 1'b1;

        // Free-running rate, speed changes, mem_ready stall, counter wrap
        for (int i = 0; i < 22; i++) begin
            bus.speed_sel = vecs[i].speed;
            bus.mem_ready = vecs[i].mr;
            cyc(vecs[i].n);
            check($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].tick));
            check($sformatf("vec%0d_count", i), 32'(bus.tick_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_running", i), 32'(bus.running), 32'd1);
        end

        // Halt via run button with memory stalled; event latency 2+4 cycles
        bus.speed_sel = 2'd0;
        bus.mem_ready = 1'b0;
        run_btn = 1'b1;
        cyc(6);
        check("halt_before", 32'(bus.running), 32'd1);
        cyc(1);
        check("halt_after", 32'(bus.running), 32'd0);
        run_btn = 1'b0;
        cyc(8);
        check("halt_count", 32'(bus.tick_count), 32'd1);

        // Step glitch shorter than debounce window is ignored
        bus.mem_ready = 1'b1;
        step_btn = 1'b1;
        cyc(2);
        step_btn = 1'b0;
        watch_ticks("glitch_tick", 10, 0);
        check("glitch_count", 32'(bus.tick_count), 32'd1);

        // Clean step press gives one tick, 1 cycle after the event
        step_btn = 1'b1;
        watch_ticks("step_tick", 10, 7);
        step_btn = 1'b0;
        cyc(8);
        check("step_count", 32'(bus.tick_count), 32'd2);
        check("step_running", 32'(bus.running), 32'd0);

        // Two presses while not ready collapse to a single tick
        bus.mem_ready = 1'b0;
        step_btn = 1'b1;
        watch_ticks("pend1_tick", 10, 0);
        step_btn = 1'b0;
        cyc(8);
        step_btn = 1'b1;
        watch_ticks("pend2_tick", 10, 0);
        step_btn = 1'b0;
        cyc(8);
        bus.mem_ready = 1'b1;
        watch_ticks("pend_ready_tick", 6, 1);
        check("pend_count", 32'(bus.tick_count), 32'd3);

        // Run and step together from HALT: run wins, no step tick
        run_btn  = 1'b1;
        step_btn = 1'b1;
        cyc(6);
        check("both_before", 32'(bus.running), 32'd0);
        cyc(1);
        check("both_running", 32'(bus.running), 32'd1);
        check("both_tick", 32'(bus.tick), 32'd0);
        cyc(1);
        check("both_tick_next", 32'(bus.tick), 32'd0);
        check("both_count", 32'(bus.tick_count), 32'd3);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        cyc(6);
        check("resume_tick_early", 32'(bus.tick), 32'd0);
        cyc(1);
        check("resume_tick", 32'(bus.tick), 32'd1);
        check("resume_count", 32'(bus.tick_count), 32'd4);

        // Asynchronous reset mid-cycle while tick is high
        #2;
        reset_n = 1'b0;
        #1;
        check("async_tick", 32'(bus.tick), 32'd0);
        check("async_count", 32'(bus.tick_count), 32'd0);
        check("async_running", 32'(bus.running), 32'd1);
        cyc(1);
        reset_n = 1'b1;
        bus.speed_sel = 2'd0;
        bus.mem_ready = 1'b1;

`ifdef TICK_BREAK_EN
        // Breakpoint at terminal halts without a tick; a step walks past it
        break_en   = 1'b1;
        pc         = 16'h0010;
        break_addr = 16'h0010;
        cyc(8);
        check("brk_tick", 32'(bus.tick), 32'd0);
        check("brk_running", 32'(bus.running), 32'd0);
        check("brk_hit", 32'(break_hit), 32'd1);
        check("brk_count", 32'(bus.tick_count), 32'd0);
        step_btn = 1'b1;
        watch_ticks("brk_step_tick", 8, 7);
        step_btn = 1'b0;
        check("brk_hit_clear", 32'(break_hit), 32'd0);
        check("brk_step_count", 32'(bus.tick_count), 32'd1);
`else
        // Without breakpoints, RUN keeps ticking after reset
        cyc(8);
        check("post_reset_tick", 32'(bus.tick), 32'd1);
        check("post_reset_count", 32'(bus.tick_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
